// File: rtl/mips_mc_if.sv
// Control bundle between the multicycle MIPS control FSM and its datapath.
//
// Controller inputs : op, funct (instruction register fields), zero (ALU flag),
//                     mem_ready (unified memory completes the access this cycle)
// Controller outputs: iord, memread, memwrite, irwrite, regdst, memtoreg,
//                     regwrite, alusrca, alusrcb, pcsrc, pcen, alucontrl
//
// master = controller side, slave = datapath/memory side.
interface mips_mc_if #(
    parameter int ALU_CTRL_WIDTH = 3
);
    logic [5:0]                op;
    logic [5:0]                funct;
    logic                      zero;
    logic                      mem_ready;
    logic                      iord;
    logic                      memread;
    logic                      memwrite;
    logic                      irwrite;
    logic                      regdst;
    logic                      memtoreg;
    logic                      regwrite;
    logic                      alusrca;
    logic [1:0]                alusrcb;
    logic [1:0]                pcsrc;
    logic                      pcen;
    logic [ALU_CTRL_WIDTH-1:0] alucontrl;

    modport master (
        input  op, funct, zero, mem_ready,
        output iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrl
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
               alusrca, alusrcb, pcsrc, pcen, alucontrl
    );
endinterface

// File: rtl/mips_mc_controller.sv
// Main control FSM of the multicycle MIPS core. Sequences the shared ALU and
// the unified instruction/data memory port over 3-5 cycles per instruction.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous active-low reset
//   bus            mips_mc_if.master: opcode/funct/zero/mem_ready in,
//                  datapath mux selects, write enables and ALU control out
//   state_dbg      current FSM state encoding
//   illegal_instr  one-cycle pulse on an unsupported opcode or funct
//   retired        count of completed instructions (wraps)
//
// state   | meaning
// FETCH   | read instruction at PC, PC+4 on the ALU, wait for mem_ready
// DECODE  | dispatch on op, precompute branch target PC+(imm<<2)
// MEMADR  | rs + signimm -> effective address
// MEMRD   | load data read, held until mem_ready
// MEMWB   | load data -> rt
// MEMWR   | store write, held until mem_ready
// EXECUTE | R-type ALU operation selected by funct
// ALUWB   | ALU result -> rd
// BEQ     | rs - rt, take branch when zero
// ADDIEX  | rs + signimm
// ADDIWB  | ALU result -> rt
// JUMP    | load jump target into PC
module mips_mc_controller #(
    parameter int ALU_CTRL_WIDTH   = 3,
    parameter int RETIRE_CNT_WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mips_mc_if.master                   bus,
    output logic [3:0]                  state_dbg,
    output logic                        illegal_instr,
    output logic [RETIRE_CNT_WIDTH-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BEQ     = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    state_t     state_q;
    state_t     state_nxt;
    logic       retire;
    logic       illegal;
    logic [2:0] alu_op;
    logic       iord_c, memread_c, memwrite_c, irwrite_c, regdst_c;
    logic       memtoreg_c, regwrite_c, alusrca_c, pcen_c;
    logic [1:0] alusrcb_c, pcsrc_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            retired <= '0;
        end else begin
            state_q <= state_nxt;
            if (retire) begin
                retired <= retired + RETIRE_CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        state_nxt  = state_q;
        retire     = 1'b0;
        illegal    = 1'b0;
        alu_op     = 3'b000;
        iord_c     = 1'b0;
        memread_c  = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regdst_c   = 1'b0;
        memtoreg_c = 1'b0;
        regwrite_c = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        pcsrc_c    = 2'b00;
        pcen_c     = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                memread_c = 1'b1;
                alusrcb_c = 2'b01;
                alu_op    = ALU_ADD;
                if (bus.mem_ready) begin
                    irwrite_c = 1'b1;
                    pcen_c    = 1'b1;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                alusrcb_c = 2'b11;
                alu_op    = ALU_ADD;
                case (bus.op)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_RTYPE:     state_nxt = S_EXECUTE;
                    OP_BEQ:       state_nxt = S_BEQ;
                    OP_ADDI:      state_nxt = S_ADDIEX;
                    OP_J:         state_nxt = S_JUMP;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                alu_op    = ALU_ADD;
                state_nxt = (bus.op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord_c    = 1'b1;
                memread_c = 1'b1;
                if (bus.mem_ready) begin
                    state_nxt = S_MEMWB;
                end
            end
            S_MEMWB: begin
                memtoreg_c = 1'b1;
                regwrite_c = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                if (bus.mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alusrca_c = 1'b1;
                state_nxt = S_ALUWB;
                case (bus.funct)
                    6'b100000: alu_op = ALU_ADD;
                    6'b100010: alu_op = ALU_SUB;
                    6'b100100: alu_op = ALU_AND;
                    6'b100101: alu_op = ALU_OR;
                    6'b101010: alu_op = ALU_SLT;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_ALUWB: begin
                regdst_c   = 1'b1;
                regwrite_c = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_BEQ: begin
                alusrca_c = 1'b1;
                alu_op    = ALU_SUB;
                pcsrc_c   = 2'b01;
                pcen_c    = bus.zero;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_ADDIEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                alu_op    = ALU_ADD;
                state_nxt = S_ADDIWB;
            end
            S_ADDIWB: begin
                regwrite_c = 1'b1;
                retire     = 1'b1;
                state_nxt  = S_FETCH;
            end
            S_JUMP: begin
                pcsrc_c   = 2'b10;
                pcen_c    = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            default: state_nxt = S_FETCH;
        endcase
    end

    // Reset parks the FSM in FETCH, whose decode would otherwise request a
    // memory read and (with mem_ready high) load PC/IR while rst_n is low.
    // The load enables and the memory request are therefore qualified by rst_n.
    assign bus.iord      = iord_c;
    assign bus.memread   = memread_c & rst_n;
    assign bus.memwrite  = memwrite_c;
    assign bus.irwrite   = irwrite_c & rst_n;
    assign bus.regdst    = regdst_c;
    assign bus.memtoreg  = memtoreg_c;
    assign bus.regwrite  = regwrite_c;
    assign bus.alusrca   = alusrca_c;
    assign bus.alusrcb   = alusrcb_c;
    assign bus.pcsrc     = pcsrc_c;
    assign bus.pcen      = pcen_c & rst_n;
    assign bus.alucontrl = ALU_CTRL_WIDTH'(alu_op);

    assign state_dbg     = state_q;
    assign illegal_instr = illegal;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Scoreboard bench for mips_mc_controller. A driver issues instructions (random
// and directed) and, for every clock cycle, pushes the response the reference
// model predicts; a monitor on the falling edge pops and compares.
module tb_mips_mc_controller;

    localparam int RW = 4;

    typedef struct packed {
        logic [3:0] st;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic       pcen;
        logic [2:0] aluc;
        logic       ill;
        logic [3:0] ret;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    state_dbg;
    logic          illegal_instr;
    logic [RW-1:0] retired;

    mips_mc_if #(.ALU_CTRL_WIDTH(3)) bus ();

    mips_mc_controller #(
        .ALU_CTRL_WIDTH  (3),
        .RETIRE_CNT_WIDTH(RW)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.master),
        .state_dbg    (state_dbg),
        .illegal_instr(illegal_instr),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   model_ret = 0;
    int   cyc_no = 0;

    function automatic exp_t sample();
        exp_t a;
        a.st       = state_dbg;
        a.iord     = bus.iord;
        a.memread  = bus.memread;
        a.memwrite = bus.memwrite;
        a.irwrite  = bus.irwrite;
        a.regdst   = bus.regdst;
        a.memtoreg = bus.memtoreg;
        a.regwrite = bus.regwrite;
        a.alusrca  = bus.alusrca;
        a.alusrcb  = bus.alusrcb;
        a.pcsrc    = bus.pcsrc;
        a.pcen     = bus.pcen;
        a.aluc     = bus.alucontrl;
        a.ill      = illegal_instr;
        a.ret      = retired;
        return a;
    endfunction

    // Monitor: one expected snapshot per driven cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        cyc_no++;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample();
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL cycle_%0d state: got st=%0d bits=%h expected st=%0d bits=%h",
                         cyc_no, a.st, a, e.st, e);
            end
        end
    end

    function automatic exp_t base(input logic [3:0] st);
        exp_t e = '0;
        e.st  = st;
        e.ret = 4'(model_ret % 16);
        return e;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // ALU code table for R-type functs; ok=0 for anything unsupported.
    function automatic logic [2:0] alu_ref(input logic [5:0] f, output logic ok);
        ok = 1'b1;
        case (f)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default: begin
                ok = 1'b0;
                return 3'b000;
            end
        endcase
    endfunction

    task automatic cyc(input logic rdy, input logic z, input exp_t e);
        bus.mem_ready = rdy;
        bus.zero      = z;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and predict every cycle of its execution.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                             input int fs, input int ms);
        exp_t e;
        logic ok;
        bus.op    = op;
        bus.funct = fn;
        e = base(4'd0);
        e.memread = 1'b1;
        e.alusrcb = 2'b01;
        e.aluc    = 3'b010;
        for (int i = 0; i < fs; i++) cyc(1'b0, rb(), e);
        e.irwrite = 1'b1;
        e.pcen    = 1'b1;
        cyc(1'b1, rb(), e);

        e = base(4'd1);
        e.alusrcb = 2'b11;
        e.aluc    = 3'b010;
        if (!(op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})) begin
            e.ill = 1'b1;
            cyc(rb(), rb(), e);
            return;
        end
        cyc(rb(), rb(), e);

        case (op)
            6'b100011, 6'b101011: begin
                e = base(4'd2);
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                e.aluc    = 3'b010;
                cyc(rb(), rb(), e);
                if (op == 6'b100011) begin
                    e = base(4'd3);
                    e.iord    = 1'b1;
                    e.memread = 1'b1;
                    for (int i = 0; i < ms; i++) cyc(1'b0, rb(), e);
                    cyc(1'b1, rb(), e);
                    e = base(4'd4);
                    e.memtoreg = 1'b1;
                    e.regwrite = 1'b1;
                    cyc(rb(), rb(), e);
                end else begin
                    e = base(4'd5);
                    e.iord     = 1'b1;
                    e.memwrite = 1'b1;
                    for (int i = 0; i < ms; i++) cyc(1'b0, rb(), e);
                    cyc(1'b1, rb(), e);
                end
            end
            6'b000000: begin
                e = base(4'd6);
                e.alusrca = 1'b1;
                e.aluc    = alu_ref(fn, ok);
                e.ill     = !ok;
                cyc(rb(), rb(), e);
                if (!ok) return;
                e = base(4'd7);
                e.regdst   = 1'b1;
                e.regwrite = 1'b1;
                cyc(rb(), rb(), e);
            end
            6'b000100: begin
                e = base(4'd8);
                e.alusrca = 1'b1;
                e.aluc    = 3'b110;
                e.pcsrc   = 2'b01;
                e.pcen    = z;
                cyc(rb(), z, e);
            end
            6'b001000: begin
                e = base(4'd9);
                e.alusrca = 1'b1;
                e.alusrcb = 2'b10;
                e.aluc    = 3'b010;
                cyc(rb(), rb(), e);
                e = base(4'd10);
                e.regwrite = 1'b1;
                cyc(rb(), rb(), e);
            end
            default: begin
                e = base(4'd11);
                e.pcsrc = 2'b10;
                e.pcen  = 1'b1;
                cyc(rb(), rb(), e);
            end
        endcase
        model_ret = (model_ret + 1) % 16;
    endtask

    task automatic check_direct(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] fn;
        logic       ok;
        int         k;
        bus.op        = '0;
        bus.funct     = '0;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b1;
        #3;
        check_direct("reset_state", int'(state_dbg), 0);
        check_direct("reset_retired", int'(retired), 0);
        check_direct("reset_pcen", int'(bus.pcen), 0);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;

        run_instr(6'b100011, 6'd0, 1'b0, 0, 0);          // lw, ready tied
        run_instr(6'b000000, 6'b100000, 1'b0, 0, 0);     // add
        run_instr(6'b101011, 6'd0, 1'b0, 0, 3);          // sw, 3 wait cycles
        run_instr(6'b000100, 6'd0, 1'b1, 0, 0);          // beq taken
        run_instr(6'b000100, 6'd0, 1'b0, 0, 0);          // beq not taken
        run_instr(6'b001000, 6'd0, 1'b0, 2, 0);          // addi, fetch stall 2
        run_instr(6'b111111, 6'd0, 1'b0, 0, 0);          // illegal op
        run_instr(6'b000000, 6'b000011, 1'b0, 0, 0);     // illegal funct
        run_instr(6'b000010, 6'd0, 1'b0, 1, 0);          // j

        // Reset in the middle of EXECUTE, with mem_ready high.
        bus.op        = 6'b000000;
        bus.funct     = 6'b100010;
        bus.mem_ready = 1'b1;
        begin
            exp_t e;
            e = base(4'd0);
            e.memread = 1'b1;
            e.alusrcb = 2'b01;
            e.aluc    = 3'b010;
            e.irwrite = 1'b1;
            e.pcen    = 1'b1;
            cyc(1'b1, 1'b0, e);
            e = base(4'd1);
            e.alusrcb = 2'b11;
            e.aluc    = 3'b010;
            cyc(1'b1, 1'b0, e);
        end
        check_direct("exec_before_reset", int'(state_dbg), 6);
        #2;
        rst_n = 1'b0;
        #1;
        check_direct("midreset_state", int'(state_dbg), 0);
        check_direct("midreset_retired", int'(retired), 0);
        check_direct("midreset_regwrite", int'(bus.regwrite), 0);
        check_direct("midreset_pcen", int'(bus.pcen), 0);
        model_ret = 0;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.mem_ready = 1'b0;
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) run_instr(6'b000010, 6'd0, 1'b0, 0, 0);
        check_direct("wrap_retired", int'(retired), 1);

        for (int n = 0; n < 250; n++) begin
            k = $urandom_range(0, 7);
            fn = 6'($urandom_range(0, 63));
            case (k)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: begin
                    op = 6'b000000;
                    case ($urandom_range(0, 4))
                        0: fn = 6'b100000;
                        1: fn = 6'b100010;
                        2: fn = 6'b100100;
                        3: fn = 6'b100101;
                        default: fn = 6'b101010;
                    endcase
                end
                3: begin
                    op = 6'b000000;
                    void'(alu_ref(fn, ok));
                    while (ok) begin
                        fn = 6'($urandom_range(0, 63));
                        void'(alu_ref(fn, ok));
                    end
                end
                4: op = 6'b000100;
                5: op = 6'b001000;
                6: op = 6'b000010;
                default: begin
                    op = 6'($urandom_range(0, 63));
                    while (op inside {6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010})
                        op = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(op, fn, rb(), $urandom_range(0, 2), $urandom_range(0, 3));
        end

        @(negedge clk);
        #1;
        check_direct("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
